// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory bus between the
// instruction-fetch port and the data-access port, with a bus watchdog.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BSEL_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [BSEL_W-1:0] mem_bsel,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              bus_en,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [BSEL_W-1:0] bus_bsel,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        BUS_IF,
        BUS_MEM
    } state_t;

    // The watchdog fires when the last allowed stall cycle is reached.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       last_mem;
    logic       elig_if;
    logic       elig_mem;
    logic       grant_if;
    logic       grant_mem;
    logic       timeout_hit;
    logic [7:0] cnt_inc;

    // Eligibility (a port is not re-granted while its ack is high) and tie-break.
    always_comb begin
        elig_if     = if_req & ~if_ack;
        elig_mem    = mem_req & ~mem_ack;
        grant_mem   = elig_mem & ~(elig_if & last_mem);
        grant_if    = elig_if & ~grant_mem;
        timeout_hit = (cnt >= CNT_LAST);
        cnt_inc     = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last_mem  <= 1'b0;
            bus_en    <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_bsel  <= '0;
            bus_err   <= 1'b0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_mem) begin
                        state     <= BUS_MEM;
                        last_mem  <= 1'b1;
                        bus_en    <= 1'b1;
                        bus_we    <= mem_we;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                        bus_bsel  <= mem_bsel;
                    end else if (grant_if) begin
                        state     <= BUS_IF;
                        last_mem  <= 1'b0;
                        bus_en    <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= if_addr;
                        bus_wdata <= '0;
                        bus_bsel  <= '1;
                    end
                end
                BUS_IF: begin
                    if (bus_ready) begin
                        if_rdata <= bus_rdata;
                        if_ack   <= 1'b1;
                        bus_en   <= 1'b0;
                        bus_we   <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                        if (timeout_hit) begin
                            if_rdata <= '0;
                            if_ack   <= 1'b1;
                            bus_err  <= 1'b1;
                            bus_en   <= 1'b0;
                            bus_we   <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                BUS_MEM: begin
                    if (bus_ready) begin
                        if (!bus_we) begin
                            mem_rdata <= bus_rdata;
                        end
                        mem_ack <= 1'b1;
                        bus_en  <= 1'b0;
                        bus_we  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                        if (timeout_hit) begin
                            mem_rdata <= '0;
                            mem_ack   <= 1'b1;
                            bus_err   <= 1'b1;
                            bus_en    <= 1'b0;
                            bus_we    <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios followed by random traffic
// against a word-level memory model of both requesters.
module tb_mem_bus_arbiter;

    localparam int TO = 4;
    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req, if_ack, mem_req, mem_we, mem_ack;
    logic        bus_en, bus_we, bus_ready, bus_err;
    logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  mem_bsel, bus_bsel;

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .BSEL_W(4), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_bsel(mem_bsel),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_bsel(bus_bsel),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // directed-phase state
    int   grants, acks, cyc;
    logic prev_en, mem_turn;

    // random-phase state
    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];
    logic        if_pend, mem_pend, in_txn, aborted;
    logic [3:0]  if_idx, mem_idx;
    int          if_age, mem_age, k, w, last_w;
    logic [31:0] exp_if_rd, exp_mem_rd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("acks_exclusive", 32'(if_ack & mem_ack), 32'd0);
        chk("err_only_with_ack", 32'(bus_err & ~(if_ack | mem_ack)), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"}, 32'(bus_en), 32'd0);
        chk({tag, "_we"}, 32'(bus_we), 32'd0);
        chk({tag, "_if_ack"}, 32'(if_ack), 32'd0);
        chk({tag, "_mem_ack"}, 32'(mem_ack), 32'd0);
        chk({tag, "_err"}, 32'(bus_err), 32'd0);
        chk({tag, "_addr"}, bus_addr, 32'd0);
        chk({tag, "_wdata"}, bus_wdata, 32'd0);
        chk({tag, "_bsel"}, 32'(bus_bsel), 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_mem_rdata"}, mem_rdata, 32'd0);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit observed=expired required=finish");
        $fatal(1, "time limit");
    end

    initial begin
        if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
        mem_addr = 0; mem_wdata = 0; mem_bsel = 0;
        bus_rdata = 0; bus_ready = 0;

        // reset state
        tick(); tick();
        chk_all_zero("reset");
        rst = 1;

        // IF read, zero wait states
        if_req = 1; if_addr = 32'h0040_0000;
        bus_ready = 1; bus_rdata = 32'h8C08_0004;
        tick();
        chk("if0_en", 32'(bus_en), 32'd1);
        chk("if0_addr", bus_addr, 32'h0040_0000);
        chk("if0_bsel", 32'(bus_bsel), 32'hF);
        chk("if0_we", 32'(bus_we), 32'd0);
        chk("if0_early_ack", 32'(if_ack), 32'd0);
        tick();
        chk("if0_ack", 32'(if_ack), 32'd1);
        chk("if0_en_low", 32'(bus_en), 32'd0);
        chk("if0_rdata", if_rdata, 32'h8C08_0004);
        if_req = 0; bus_ready = 0;
        tick();
        chk("if0_ack_pulse", 32'(if_ack), 32'd0);
        chk("if0_en_idle", 32'(bus_en), 32'd0);

        // MEM write, ready in the 4th bus cycle
        mem_req = 1; mem_we = 1; mem_addr = 32'h1001_0008;
        mem_wdata = 32'hDEAD_BEEF; mem_bsel = 4'b0011;
        bus_rdata = 32'h1234_5678;
        tick();
        for (int i = 1; i <= 4; i++) begin
            chk("wr_en", 32'(bus_en), 32'd1);
            chk("wr_we", 32'(bus_we), 32'd1);
            chk("wr_addr", bus_addr, 32'h1001_0008);
            chk("wr_wdata", bus_wdata, 32'hDEAD_BEEF);
            chk("wr_bsel", 32'(bus_bsel), 32'h3);
            chk("wr_early_ack", 32'(mem_ack), 32'd0);
            bus_ready = (i == 4);
            tick();
        end
        chk("wr_ack", 32'(mem_ack), 32'd1);
        chk("wr_no_err", 32'(bus_err), 32'd0);
        chk("wr_en_low", 32'(bus_en), 32'd0);
        chk("wr_we_low", 32'(bus_we), 32'd0);
        chk("wr_rdata_kept", mem_rdata, 32'd0);
        mem_req = 0; bus_ready = 0;
        tick();
        chk("wr_ack_pulse", 32'(mem_ack), 32'd0);

        // simultaneous requests from reset, held for 6 grants
        rst = 0;
        tick();
        rst = 1;
        mem_we = 0; mem_addr = 32'h1001_0000; mem_bsel = 4'hF;
        if_addr = 32'h0040_0010; bus_ready = 1;
        if_req = 1; mem_req = 1;
        grants = 0; acks = 0; cyc = 0; prev_en = 0; mem_turn = 1;
        while (acks < 6 && cyc < 60) begin
            tick();
            cyc++;
            if (bus_en && !prev_en) begin
                grants++;
                chk("arb_order", bus_addr, mem_turn ? mem_addr : if_addr);
                mem_turn = !mem_turn;
            end
            if (if_ack) begin
                acks++;
                chk("arb_if_rdata", if_rdata, if_addr ^ K);
            end
            if (mem_ack) begin
                acks++;
                chk("arb_mem_rdata", mem_rdata, mem_addr ^ K);
            end
            if (acks >= 6) begin
                if_req = 0; mem_req = 0;
            end
            prev_en = bus_en;
            bus_rdata = bus_addr ^ K;
        end
        chk("arb_acks", 32'(acks), 32'd6);
        chk("arb_grants", 32'(grants), 32'd6);
        bus_ready = 0;
        tick();
        chk("arb_no_extra", 32'(bus_en), 32'd0);

        // watchdog abort on a MEM read
        mem_req = 1; mem_we = 0; mem_addr = 32'h1001_0020;
        bus_rdata = 32'hFFFF_FFFF;
        tick();
        for (int i = 1; i <= 4; i++) begin
            chk("to_en", 32'(bus_en), 32'd1);
            chk("to_early_ack", 32'(mem_ack), 32'd0);
            tick();
        end
        chk("to_ack", 32'(mem_ack), 32'd1);
        chk("to_err", 32'(bus_err), 32'd1);
        chk("to_rdata", mem_rdata, 32'd0);
        chk("to_en_low", 32'(bus_en), 32'd0);
        mem_req = 0;
        tick();
        chk("to_err_pulse", 32'(bus_err), 32'd0);

        // ready exactly in the last allowed cycle
        mem_req = 1; bus_rdata = 32'hCAFE_F00D;
        tick();
        for (int i = 1; i <= 4; i++) begin
            chk("edge_en", 32'(bus_en), 32'd1);
            bus_ready = (i == 4);
            tick();
        end
        chk("edge_ack", 32'(mem_ack), 32'd1);
        chk("edge_no_err", 32'(bus_err), 32'd0);
        chk("edge_rdata", mem_rdata, 32'hCAFE_F00D);
        mem_req = 0; bus_ready = 0;
        tick();

        // reset during a stalled IF access
        if_req = 1; if_addr = 32'h0040_0100;
        tick();
        chk("rst_if_en", 32'(bus_en), 32'd1);
        tick();
        rst = 0;
        tick();
        chk_all_zero("rst_mid");
        rst = 1; bus_ready = 1; bus_rdata = 32'h0BAD_F00D;
        tick();
        chk("rst_fresh_en", 32'(bus_en), 32'd1);
        chk("rst_fresh_addr", bus_addr, 32'h0040_0100);
        chk("rst_fresh_noack", 32'(if_ack), 32'd0);
        tick();
        chk("rst_fresh_ack", 32'(if_ack), 32'd1);
        chk("rst_fresh_rdata", if_rdata, 32'h0BAD_F00D);
        if_req = 0; bus_ready = 0;
        tick();

        // IF request dropped after one cycle of a 3-wait access
        if_req = 1; if_addr = 32'h0040_0200; bus_rdata = 32'h2402_0007;
        tick();
        if_req = 0;
        for (int i = 1; i <= 4; i++) begin
            chk("drop_en", 32'(bus_en), 32'd1);
            bus_ready = (i == 4);
            tick();
        end
        chk("drop_ack", 32'(if_ack), 32'd1);
        chk("drop_rdata", if_rdata, 32'h2402_0007);
        bus_ready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("drop_no_regrant", 32'(bus_en), 32'd0);
            chk("drop_single_ack", 32'(if_ack), 32'd0);
        end

        // random traffic against a word memory model
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end
        exp_if_rd = 32'h2402_0007;
        exp_mem_rd = 32'd0;
        if_pend = 0; mem_pend = 0; in_txn = 0;
        if_age = 0; mem_age = 0; k = 0; w = 0; last_w = 0;
        if_idx = 0; mem_idx = 0;
        for (int c = 0; c < 700; c++) begin
            tick();
            if (if_ack) begin
                aborted = (last_w >= TO);
                chk("rnd_if_pending", 32'(if_pend), 32'd1);
                chk("rnd_if_err", 32'(bus_err), 32'(aborted));
                chk("rnd_if_addr", bus_addr, BASE + 32'(if_idx) * 4);
                chk("rnd_if_bsel", 32'(bus_bsel), 32'hF);
                chk("rnd_if_wdata", bus_wdata, 32'd0);
                exp_if_rd = aborted ? 32'd0 : ref_mem[if_idx];
                chk("rnd_if_rdata", if_rdata, exp_if_rd);
                if_pend = 0; if_req = 0;
            end
            if (mem_ack) begin
                aborted = (last_w >= TO);
                chk("rnd_mem_pending", 32'(mem_pend), 32'd1);
                chk("rnd_mem_err", 32'(bus_err), 32'(aborted));
                chk("rnd_mem_addr", bus_addr, BASE + 32'(mem_idx) * 4);
                chk("rnd_mem_bsel", 32'(bus_bsel), 32'(mem_bsel));
                chk("rnd_mem_wdata", bus_wdata, mem_wdata);
                if (aborted) exp_mem_rd = 32'd0;
                else if (mem_we)
                    ref_mem[mem_idx] = merge(ref_mem[mem_idx], mem_wdata, mem_bsel);
                else exp_mem_rd = ref_mem[mem_idx];
                chk("rnd_mem_rdata", mem_rdata, exp_mem_rd);
                mem_pend = 0; mem_req = 0;
            end
            if (if_pend) if_age++;
            if (mem_pend) mem_age++;
            if (if_pend && if_age == 40) begin
                chk("rnd_if_latency", 32'(if_age), 32'd0);
                if_pend = 0; if_req = 0;
            end
            if (mem_pend && mem_age == 40) begin
                chk("rnd_mem_latency", 32'(mem_age), 32'd0);
                mem_pend = 0; mem_req = 0;
            end
            if (bus_en) begin
                if (!in_txn) begin
                    in_txn = 1; k = 0;
                    w = int'($urandom_range(0, 5));
                    last_w = w;
                end
                bus_rdata = slv_mem[bus_addr[5:2]];
                bus_ready = (k == w);
                if (bus_ready && bus_we)
                    slv_mem[bus_addr[5:2]] =
                        merge(slv_mem[bus_addr[5:2]], bus_wdata, bus_bsel);
                k++;
            end else begin
                in_txn = 0; bus_ready = 0; bus_rdata = $urandom;
            end
            if (c < 600 && !if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_age = 0;
                if_idx = 4'($urandom_range(0, 15));
                if_addr = BASE + 32'(if_idx) * 4;
                if_req = 1;
            end
            if (c < 600 && !mem_pend && $urandom_range(0, 2) == 0) begin
                mem_pend = 1; mem_age = 0;
                mem_idx = 4'($urandom_range(0, 15));
                mem_addr = BASE + 32'(mem_idx) * 4;
                mem_we = 1'($urandom_range(0, 1));
                mem_wdata = $urandom;
                mem_bsel = 4'($urandom_range(0, 15));
                mem_req = 1;
            end
        end
        chk("rnd_if_drained", 32'(if_pend), 32'd0);
        chk("rnd_mem_drained", 32'(mem_pend), 32'd0);
        for (int i = 0; i < 16; i++)
            chk("rnd_mem_image", slv_mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequential arbiter sharing one single-port memory bus between the instruction-fetch port (IF stage) and the data-access port (MEM stage, driven by `WriteMem`/`ReadMem`/`byte_slct` from decode). It accepts one request per port, grants the bus to one port at a time through a three-state FSM, and holds the transaction until the bus signals ready or a watchdog times out. It returns read data with a one-cycle acknowledge pulse that the pipeline uses to release its stalls.

## Interface
- `ADDR_W`, default 32: address width (matches `InstAddrWidth`).
- `DATA_W`, default 32: data width (matches `RegDataWidth`).
- `BSEL_W`, default 4: byte-select width (matches `ByteSlctWidth`).
- `TIMEOUT`, default 255: maximum number of cycles in a bus state before abort; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req` is high.
- `if_rdata`  out  DATA_W  fetched word; registered.
- `if_ack`  out  1  one-cycle completion pulse.
- `mem_req`  in  1  data request; held until `mem_ack`.
- `mem_we`  in  1  1 = write, 0 = read.
- `mem_addr`  in  ADDR_W  data address.
- `mem_wdata`  in  DATA_W  write data.
- `mem_bsel`  in  BSEL_W  byte lane enables.
- `mem_rdata`  out  DATA_W  read data; registered.
- `mem_ack`  out  1  one-cycle completion pulse.
- `bus_en`  out  1  bus transaction active.
- `bus_we`  out  1  bus write strobe.
- `bus_addr`  out  ADDR_W  bus address.
- `bus_wdata`  out  DATA_W  bus write data.
- `bus_bsel`  out  BSEL_W  bus byte enables; all ones for IF.
- `bus_rdata`  in  DATA_W  bus read data; valid when `bus_ready` is high.
- `bus_ready`  in  1  bus completes the current transaction this cycle.
- `bus_err`  out  1  one-cycle pulse on watchdog abort.

## Operation
- FSM states: IDLE, BUS_IF, BUS_MEM. All outputs are registered.
- Eligibility, evaluated in IDLE only:
  - `elig_if = if_req & ~if_ack`
  - `elig_mem = mem_req & ~mem_ack`
  - A port whose ack is high this cycle is not re-granted on this edge.
- Grant in IDLE:
  - Only one port eligible: that port wins.
  - Both eligible: MEM wins, unless `last_mem` = 1, in which case IF wins.
  - `last_mem` is set to 1 on a MEM grant and cleared to 0 on an IF grant.
- On grant, latch the request fields into the `bus_*` registers:
  - IF: `bus_we`=0, `bus_bsel`=all ones, `bus_wdata`=0.
  - Set `bus_en`=1, clear the watchdog counter, and move to BUS_IF or BUS_MEM.
- In BUS_x with `bus_ready`=1:
  - Read: capture `bus_rdata` into `x_rdata`. Write: `x_rdata` is unchanged.
  - Pulse `x_ack`=1 for one cycle, clear `bus_en`/`bus_we`, return to IDLE.
- In BUS_x with `bus_ready`=0: the counter increments.
  - If this is the TIMEOUT-th cycle in BUS_x: abort. `x_rdata` is set to 0, and `x_ack` and `bus_err` pulse together; return to IDLE.
  - `bus_ready`=1 in the TIMEOUT-th cycle completes normally, with no error.
- Request dropped mid-transaction: the transaction still completes and the ack still pulses. Requesters hold `req` and its fields stable until ack.
- `bus_addr`/`bus_wdata`/`bus_bsel` hold their last values in IDLE.
- Counter width is 8 bits and saturates; it never wraps.

## Timing
- Reset (`rst`=0 at an edge) forces, on that edge:
  - state = IDLE
  - `bus_en`, `bus_we`, `if_ack`, `mem_ack`, `bus_err` = 0
  - `bus_addr`, `bus_wdata`, `bus_bsel`, `if_rdata`, `mem_rdata` = 0
  - counter = 0, `last_mem` = 0
- Reset mid-transaction aborts silently: no ack, no error pulse.
- Request sampled at edge k (IDLE) → `bus_en` high in cycle k+1.
- `bus_ready` high at edge m → ack and rdata valid in cycle m+1, with `bus_en` already low.
- Zero-wait-state access: 2 cycles from request to ack.
- Minimum spacing between grants to the same port is 3 cycles; the other port can be granted in the ack cycle.
- `bus_en` is never high for two different ports without an intervening IDLE cycle.
- `if_ack` and `mem_ack` are never high in the same cycle.

## Test plan
- Reset, then IF read at 0x00400000 with `bus_ready` tied high and `bus_rdata`=0x8C080004 → `bus_en` high for exactly 1 cycle; `if_ack` is a 1-cycle pulse 2 cycles after the request; `if_rdata`=0x8C080004.
- MEM write (`mem_addr`=0x10010008, `mem_wdata`=0xDEADBEEF, `mem_bsel`=0011) with `bus_ready` delayed 3 cycles → bus fields match for 4 cycles with `bus_we`=1; `mem_ack` pulses; `mem_rdata` unchanged.
- IF and MEM both requested at the same edge from reset, each reissued right after its ack, for 6 grants → order MEM, IF, MEM, IF, …; no overlapping `bus_en`; acks never coincide.
- `TIMEOUT`=4 with `bus_ready` held at 0 on a MEM read → after 4 bus cycles `mem_ack` and `bus_err` pulse together and `mem_rdata`=0; a repeat with `bus_ready` high in cycle 4 → normal completion, `bus_err`=0.
- `rst` driven low during cycle 2 of a stalled IF access → next cycle all outputs are 0 and state is IDLE; no `if_ack`; a fresh request after reset is served normally.
- IF request dropped after 1 cycle of a 3-wait-state access → transaction completes and `if_ack` still pulses once; no second grant occurs.
